hcsr04_emulador: RTL

Synthesizable behavioural model of the HC-SR04 ultrasonic sensor. It is the responder end of the trigger/echo protocol driven by the sensor interface: it accepts a trigger pulse, waits a burst delay, then drives an echo pulse whose width encodes a programmable distance. It is used on-board as a sensor stand-in and in benches as the device under the interface.

---
 rtl/hcsr04_emulador.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hcsr04_emulador.sv
// HC-SR04 ultrasonic sensor stand-in: answers a trigger pulse with an echo pulse
// whose width encodes a programmable distance (cm counter x cycles-per-cm counter).
module hcsr04_emulador #(
    parameter int unsigned TRIG_MIN      = 500,
    parameter int unsigned ATRASO        = 10000,
    parameter int unsigned CICLOS_POR_CM = 2941,
    parameter int unsigned DIST_MAX      = 400,
    parameter int unsigned TIMEOUT       = 1900000,
    parameter int unsigned RECUPERA      = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic        habilita,
    input  logic [11:0] distancia,
    output logic        echo,
    output logic        ocupado,
    output logic [3:0]  db_estado
);
    localparam int unsigned PROD = DIST_MAX * CICLOS_POR_CM;
    localparam int unsigned M1   = (TIMEOUT > PROD) ? TIMEOUT : PROD;
    localparam int unsigned M2   = (ATRASO > RECUPERA) ? ATRASO : RECUPERA;
    localparam int unsigned M3   = (M1 > M2) ? M1 : M2;
    localparam int unsigned MAXC = (M3 > TRIG_MIN) ? M3 : TRIG_MIN;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] TRIG_MIN_C = CW'(TRIG_MIN);
    localparam logic [CW-1:0] ATRASO_M1  = CW'(ATRASO - 1);
    localparam logic [CW-1:0] CPC_M1     = CW'(CICLOS_POR_CM - 1);
    localparam logic [CW-1:0] TIMEOUT_M1 = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] REC_M1     = CW'(RECUPERA - 1);
    localparam logic [11:0]   DMAX       = 12'(DIST_MAX);

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ESPERA       = 4'd1,
        MEDE_TRIGGER = 4'd2,
        ATRASO_ST    = 4'd3,
        ECHO_ALTO    = 4'd4,
        RECUPERA_ST  = 4'd5
    } estado_t;

    estado_t       estado, estado_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [11:0]   cm, cm_n;
    logic          sem_obj, sem_obj_n;
    logic          trig_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= INICIAL;
            cnt       <= '0;
            cm        <= '0;
            sem_obj   <= 1'b0;
            trig_prev <= 1'b0;
            echo      <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            estado    <= estado_n;
            cnt       <= cnt_n;
            cm        <= cm_n;
            sem_obj   <= sem_obj_n;
            trig_prev <= trigger;
            echo      <= (estado_n == ECHO_ALTO);
            ocupado   <= (estado_n == ATRASO_ST) || (estado_n == ECHO_ALTO) ||
                         (estado_n == RECUPERA_ST);
        end
    end

    always_comb begin
        estado_n  = estado;
        cnt_n     = cnt;
        cm_n      = cm;
        sem_obj_n = sem_obj;
        case (estado)
            INICIAL: begin
                estado_n = ESPERA;
                cnt_n    = '0;
                cm_n     = '0;
            end
            ESPERA: begin
                // trig_prev blocks a trigger that was already high on entry
                if (habilita && trigger && !trig_prev) begin
                    estado_n = MEDE_TRIGGER;
                    cnt_n    = CW'(1);
                end
            end
            MEDE_TRIGGER: begin
                if (!habilita) begin
                    estado_n = ESPERA;
                end else if (trigger) begin
                    // saturate: trigger width has no upper limit
                    if (cnt < TRIG_MIN_C) cnt_n = cnt + CW'(1);
                end else if (cnt >= TRIG_MIN_C) begin
                    estado_n  = ATRASO_ST;
                    cnt_n     = '0;
                    cm_n      = distancia;
                    sem_obj_n = (distancia == 12'd0) || (distancia > DMAX);
                end else begin
                    estado_n = ESPERA;
                end
            end
            ATRASO_ST: begin
                if (cnt == ATRASO_M1) begin
                    estado_n = ECHO_ALTO;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ECHO_ALTO: begin
                if (sem_obj) begin
                    if (cnt == TIMEOUT_M1) begin
                        estado_n = RECUPERA_ST;
                        cnt_n    = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end else if (cnt == CPC_M1) begin
                    cnt_n = '0;
                    if (cm == 12'd1) estado_n = RECUPERA_ST;
                    else             cm_n = cm - 12'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RECUPERA_ST: begin
                if (cnt == REC_M1) begin
                    estado_n = ESPERA;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: estado_n = INICIAL;
        endcase
    end

    assign db_estado = estado;
endmodule
